// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser: frames SYNC/opcode/4-byte operand packets from a UART receiver
// and presents them to the perceptron datapath with a valid/ready handshake.
module uart_cmd_parser #(
   parameter logic [7:0]  SYNC    = 8'd100,
   parameter logic [19:0] TIMEOUT = 20'd500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        cmd_ready,
   output logic        cmd_valid,
   output logic [7:0]  cmd_op,
   output logic [31:0] cmd_data,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  pkt_count
);

   typedef enum logic [1:0] {StIdle, StOpcode, StData, StHold} state_e;

   localparam logic [1:0] ErrOpcode  = 2'd1;
   localparam logic [1:0] ErrTimeout = 2'd2;
   localparam logic [1:0] ErrOverrun = 2'd3;

   state_e      state_q, state_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_op_q, cmd_op_d;
   logic [31:0] cmd_data_q, cmd_data_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  pkt_count_q, pkt_count_d;
   logic [1:0]  idx_q, idx_d;
   logic [19:0] gap_q, gap_d;

   logic op_legal;
   logic gap_expired;

   always_comb begin
      case (rx_data)
         8'd0, 8'd1, 8'd2, 8'd5, 8'd6: op_legal = 1'b1;
         default:                      op_legal = 1'b0;
      endcase
   end

   // Fires on the TIMEOUT-th consecutive idle cycle after the last byte.
   assign gap_expired = (gap_q == TIMEOUT - 20'd1);

   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      cmd_data_d  = cmd_data_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      pkt_count_d = pkt_count_q;
      idx_d       = idx_q;
      gap_d       = gap_q;

      unique case (state_q)
         StIdle: begin
            if (rx_valid && rx_data == SYNC) begin
               state_d = StOpcode;
               gap_d   = 20'd0;
            end
         end
         StOpcode: begin
            if (rx_valid) begin
               gap_d = 20'd0;
               if (op_legal) begin
                  cmd_op_d = rx_data;
                  idx_d    = 2'd0;
                  state_d  = StData;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ErrOpcode;
                  state_d    = StIdle;
               end
            end else if (gap_expired) begin
               err_d      = 1'b1;
               err_code_d = ErrTimeout;
               gap_d      = 20'd0;
               state_d    = StIdle;
            end else begin
               gap_d = gap_q + 20'd1;
            end
         end
         StData: begin
            if (rx_valid) begin
               gap_d                            = 20'd0;
               cmd_data_d[{idx_q, 3'b000} +: 8] = rx_data;
               idx_d                            = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d     = StHold;
                  cmd_valid_d = 1'b1;
               end
            end else if (gap_expired) begin
               err_d      = 1'b1;
               err_code_d = ErrTimeout;
               gap_d      = 20'd0;
               idx_d      = 2'd0;
               state_d    = StIdle;
            end else begin
               gap_d = gap_q + 20'd1;
            end
         end
         StHold: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               pkt_count_d = pkt_count_q + 8'd1;
               gap_d       = 20'd0;
               // A SYNC arriving alongside the handshake starts the next packet.
               state_d     = (rx_valid && rx_data == SYNC) ? StOpcode : StIdle;
            end else if (rx_valid) begin
               err_d      = 1'b1;
               err_code_d = ErrOverrun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= 8'd0;
         cmd_data_q  <= 32'd0;
         err_q       <= 1'b0;
         err_code_q  <= 2'd0;
         pkt_count_q <= 8'd0;
         idx_q       <= 2'd0;
         gap_q       <= 20'd0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         cmd_data_q  <= cmd_data_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         pkt_count_q <= pkt_count_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_op    = cmd_op_q;
   assign cmd_data  = cmd_data_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed packets push expected commands/errors,
// a negedge monitor pops and compares on every handshake and err pulse.
module tb_uart_cmd_parser;

   localparam logic [7:0]  SYNC    = 8'd100;
   localparam logic [19:0] TIMEOUT = 20'd20;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] data;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic [7:0]  cmd_op;
   logic [31:0] cmd_data;
   logic        err;
   logic [1:0]  err_code;
   logic [7:0]  pkt_count;

   cmd_t       exp_cmd_q[$];
   logic [1:0] exp_err_q[$];
   int         total = 0;
   int         bad = 0;
   int         valid_cycles = 0;
   int         v0;

   uart_cmd_parser #(
      .SYNC    (SYNC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .cmd_ready (cmd_ready),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .err       (err),
      .err_code  (err_code),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] op, input logic [31:0] d);
      send_byte(SYNC);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
   endtask

   // Monitor: compares every handshake and every err pulse against the scoreboard.
   initial begin
      cmd_t e;
      logic [1:0] ec;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (cmd_valid) valid_cycles++;
            if (cmd_valid && cmd_ready) begin
               if (exp_cmd_q.size() == 0) begin
                  check("unexpected_cmd", {24'd0, cmd_op}, 32'hffff_ffff);
               end else begin
                  e = exp_cmd_q.pop_front();
                  check("cmd_op", {24'd0, cmd_op}, {24'd0, e.op});
                  check("cmd_data", cmd_data, e.data);
               end
            end
            if (err) begin
               if (exp_err_q.size() == 0) begin
                  check("unexpected_err", {30'd0, err_code}, 32'hffff_ffff);
               end else begin
                  ec = exp_err_q.pop_front();
                  check("err_code", {30'd0, err_code}, {30'd0, ec});
               end
            end
         end
      end
   end

   initial begin
      tick(2);
      check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_cmd_op", {24'd0, cmd_op}, 32'd0);
      check("rst_cmd_data", cmd_data, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_pkt_count", {24'd0, pkt_count}, 32'd0);
      rst = 1'b0;
      tick(1);

      // Basic packet with ready high: exactly one valid cycle.
      cmd_ready = 1'b1;
      exp_cmd_q.push_back('{op: 8'd0, data: 32'h04030201});
      v0 = valid_cycles;
      send_pkt(8'd0, 32'h04030201);
      tick(3);
      check("basic_valid_cycles", valid_cycles - v0, 32'd1);
      check("basic_pkt_count", {24'd0, pkt_count}, 32'd1);

      // Back-pressure: valid held 50 cycles with stable command.
      cmd_ready = 1'b0;
      exp_cmd_q.push_back('{op: 8'd6, data: 32'h281E140A});
      v0 = valid_cycles;
      send_pkt(8'd6, 32'h281E140A);
      tick(49);
      check("hold_op", {24'd0, cmd_op}, 32'd6);
      check("hold_data", cmd_data, 32'h281E140A);
      cmd_ready = 1'b1;
      tick(3);
      check("hold_valid_cycles", valid_cycles - v0, 32'd50);
      check("hold_pkt_count", {24'd0, pkt_count}, 32'd2);

      // Leading junk ignored, illegal opcode flagged, then a clean packet.
      exp_err_q.push_back(2'd1);
      send_byte(8'd7);
      send_byte(SYNC);
      send_byte(8'd3);
      tick(2);
      exp_cmd_q.push_back('{op: 8'd2, data: 32'h281E140A});
      send_pkt(8'd2, 32'h281E140A);
      tick(3);
      check("badop_pkt_count", {24'd0, pkt_count}, 32'd3);

      // Timeout mid-packet: error, no command.
      exp_err_q.push_back(2'd2);
      v0 = valid_cycles;
      send_byte(SYNC);
      send_byte(8'd5);
      send_byte(8'd10);
      tick(int'(TIMEOUT) + 5);
      check("timeout_no_valid", valid_cycles - v0, 32'd0);
      check("timeout_err_code_held", {30'd0, err_code}, 32'd2);

      // Gaps of TIMEOUT-1 idle cycles must not expire.
      exp_cmd_q.push_back('{op: 8'd5, data: 32'h44332211});
      send_byte(SYNC);
      tick(int'(TIMEOUT) - 1);
      send_byte(8'd5);
      tick(int'(TIMEOUT) - 1);
      send_byte(8'h11);
      send_byte(8'h22);
      tick(int'(TIMEOUT) - 1);
      send_byte(8'h33);
      send_byte(8'h44);
      tick(3);
      check("gap_pkt_count", {24'd0, pkt_count}, 32'd4);

      // Overrun while held, then SYNC together with ready; SYNC as operand byte.
      cmd_ready = 1'b0;
      exp_cmd_q.push_back('{op: 8'd6, data: 32'hDDCCBBAA});
      send_pkt(8'd6, 32'hDDCCBBAA);
      exp_err_q.push_back(2'd3);
      tick(2);
      send_byte(SYNC);
      tick(2);
      check("overrun_still_valid", {31'd0, cmd_valid}, 32'd1);
      check("overrun_data_kept", cmd_data, 32'hDDCCBBAA);
      cmd_ready = 1'b1;
      exp_cmd_q.push_back('{op: 8'd1, data: 32'h00000064});
      send_byte(SYNC);
      send_byte(8'd1);
      send_byte(SYNC);
      send_byte(8'd0);
      send_byte(8'd0);
      send_byte(8'd0);
      tick(3);
      check("overrun_pkt_count", {24'd0, pkt_count}, 32'd6);

      // Reset mid-packet; a SYNC during reset must be ignored.
      send_byte(SYNC);
      send_byte(8'd1);
      send_byte(8'd7);
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = SYNC;
      tick(1);
      rx_valid = 1'b0;
      check("mrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      check("mrst_cmd_op", {24'd0, cmd_op}, 32'd0);
      check("mrst_cmd_data", cmd_data, 32'd0);
      check("mrst_err_code", {30'd0, err_code}, 32'd0);
      check("mrst_pkt_count", {24'd0, pkt_count}, 32'd0);
      rst = 1'b0;
      tick(1);
      exp_cmd_q.push_back('{op: 8'd2, data: 32'h0D0C0B0A});
      send_pkt(8'd2, 32'h0D0C0B0A);
      tick(3);
      check("mrst_next_pkt_count", {24'd0, pkt_count}, 32'd1);

      for (int i = 0; i < 100 && (exp_cmd_q.size() != 0 || exp_err_q.size() != 0); i++) tick(1);
      check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
      check("err_queue_drained", exp_err_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
